// File: rtl/firmware_arbiter.sv
// Firmware ROM read-port arbiter: the 6502 has fixed priority, the debug
// requester is served when the CPU is idle or by a one-cycle RDY stall.
module firmware_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_vec_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [7:0]        cpu_data_o,
   output logic              cpu_rdy_o,
   input  logic              dbg_valid_i,
   input  logic              dbg_vec_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_ready_o,
   output logic [7:0]        dbg_rdata_o,
   output logic              dbg_rvalid_o,
   output logic [ADDR_W-1:0] rom_address_o,
   output logic              rom_select_firmware_o,
   output logic              rom_select_vectors_o,
   input  logic [7:0]        rom_data_i
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   owner_e           owner;
   logic             force_stall;
   logic             dbg_grant;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;

   // Debug is locked out entirely while reset is held.
   always_comb begin
      force_stall = 1'b0;
      owner       = OWN_NONE;
      if (rst_i) begin
         owner = cpu_req_i ? OWN_CPU : OWN_NONE;
      end else if (dbg_valid_i && cpu_req_i && (wait_q == WAIT_MAX)) begin
         force_stall = 1'b1;
         owner       = OWN_DBG;
      end else if (cpu_req_i) begin
         owner = OWN_CPU;
      end else if (dbg_valid_i) begin
         owner = OWN_DBG;
      end
   end

   assign dbg_grant   = (owner == OWN_DBG);
   assign dbg_ready_o = dbg_grant;
   assign cpu_rdy_o   = ~force_stall;

   always_comb begin
      rom_address_o         = '0;
      rom_select_firmware_o = 1'b0;
      rom_select_vectors_o  = 1'b0;
      cpu_data_o            = 8'h00;
      unique case (owner)
         OWN_CPU: begin
            rom_address_o         = cpu_addr_i;
            rom_select_firmware_o = ~cpu_vec_i;
            rom_select_vectors_o  = cpu_vec_i;
            cpu_data_o            = rom_data_i;
         end
         OWN_DBG: begin
            rom_address_o         = dbg_addr_i;
            rom_select_firmware_o = ~dbg_vec_i;
            rom_select_vectors_o  = dbg_vec_i;
         end
         default: ;
      endcase
   end

   // Starvation counter saturates so the forced grant stays pending.
   always_comb begin
      wait_d = wait_q;
      if (!dbg_valid_i || dbg_grant) begin
         wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + CNT_W'(1);
      end
   end

   assign rdata_d  = dbg_grant ? rom_data_i : rdata_q;
   assign rvalid_d = dbg_grant;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q   <= '0;
         rdata_q  <= 8'h00;
         rvalid_q <= 1'b0;
      end else begin
         wait_q   <= wait_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // A read granted just before reset is dropped, not delivered.
   assign dbg_rvalid_o = rvalid_q & ~rst_i;
   assign dbg_rdata_o  = rst_i ? 8'h00 : rdata_q;

endmodule

// File: tb/tb_firmware_arbiter.sv
// Directed bench for firmware_arbiter with a behavioural ROM
// (firmware: addr[7:0]^8'h8A, vectors: 8'h30+addr[7:0]).
module tb_firmware_arbiter;

   localparam int ADDR_W   = 12;
   localparam int MAX_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_vec;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_data;
   logic              cpu_rdy;
   logic              dbg_valid, dbg_vec;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_ready;
   logic [7:0]        dbg_rdata;
   logic              dbg_rvalid;
   logic [ADDR_W-1:0] rom_addr;
   logic              sel_fw, sel_vec;
   logic [7:0]        rom_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   firmware_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .cpu_req_i            (cpu_req),
      .cpu_vec_i            (cpu_vec),
      .cpu_addr_i           (cpu_addr),
      .cpu_data_o           (cpu_data),
      .cpu_rdy_o            (cpu_rdy),
      .dbg_valid_i          (dbg_valid),
      .dbg_vec_i            (dbg_vec),
      .dbg_addr_i           (dbg_addr),
      .dbg_ready_o          (dbg_ready),
      .dbg_rdata_o          (dbg_rdata),
      .dbg_rvalid_o         (dbg_rvalid),
      .rom_address_o        (rom_addr),
      .rom_select_firmware_o(sel_fw),
      .rom_select_vectors_o (sel_vec),
      .rom_data_i           (rom_data)
   );

   always_comb begin
      rom_data = 8'hFF;
      if (sel_fw && sel_vec) rom_data = 8'hEE;
      else if (sel_fw)       rom_data = rom_addr[7:0] ^ 8'h8A;
      else if (sel_vec)      rom_data = 8'h30 + rom_addr[7:0];
   end

   // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_vec = 0; cpu_addr = '0;
      dbg_valid = 0; dbg_vec = 0; dbg_addr = '0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs(); dbg_valid = 1; dbg_addr = 12'h005;
      tick(); tick(); settle();
      checks++;
      if (dbg_ready !== 1'b0 || cpu_rdy !== 1'b1 || dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: ready=%b rdy=%b rvalid=%b rdata=%h, want 0 1 0 00",
                  dbg_ready, cpu_rdy, dbg_rvalid, dbg_rdata);
      end
      checks++;
      if (sel_fw !== 1'b0 || sel_vec !== 1'b0 || rom_addr !== 12'h000) begin
         errors++;
         $display("FAIL reset_rom_idle: fw=%b vec=%b addr=%h, want 0 0 000", sel_fw, sel_vec, rom_addr);
      end
      tick(); cpu_req = 1; cpu_addr = 12'h011; settle();
      checks++;
      if (cpu_data !== 8'h9B || dbg_ready !== 1'b0 || sel_fw !== 1'b1) begin
         errors++;
         $display("FAIL reset_cpu_owner: data=%h ready=%b fw=%b, want 9b 0 1", cpu_data, dbg_ready, sel_fw);
      end
      tick(); rst = 0; idle_inputs(); settle();
   endtask

   task automatic test_cpu_only();
      tick(); idle_inputs(); cpu_req = 1; cpu_addr = 12'h123; settle();
      checks++;
      if (cpu_data !== 8'hA9 || sel_fw !== 1'b1 || sel_vec !== 1'b0 || cpu_rdy !== 1'b1 ||
          dbg_ready !== 1'b0 || rom_addr !== 12'h123) begin
         errors++;
         $display("FAIL cpu_only: data=%h fw=%b vec=%b rdy=%b ready=%b addr=%h, want a9 1 0 1 0 123",
                  cpu_data, sel_fw, sel_vec, cpu_rdy, dbg_ready, rom_addr);
      end
      tick(); cpu_vec = 1; cpu_addr = 12'h00C; settle();
      checks++;
      if (cpu_data !== 8'h3C || sel_fw !== 1'b0 || sel_vec !== 1'b1) begin
         errors++;
         $display("FAIL cpu_vector: data=%h fw=%b vec=%b, want 3c 0 1", cpu_data, sel_fw, sel_vec);
      end
      tick(); idle_inputs(); settle();
   endtask

   task automatic test_dbg_vector();
      tick(); idle_inputs(); dbg_valid = 1; dbg_vec = 1; dbg_addr = 12'h004; settle();
      checks++;
      if (dbg_ready !== 1'b1 || sel_vec !== 1'b1 || sel_fw !== 1'b0 || cpu_data !== 8'h00 || rom_addr !== 12'h004) begin
         errors++;
         $display("FAIL dbg_grant: ready=%b vec=%b fw=%b cpu_data=%h addr=%h, want 1 1 0 00 004",
                  dbg_ready, sel_vec, sel_fw, cpu_data, rom_addr);
      end
      tick(); idle_inputs(); settle();
      checks++;
      if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'h34) begin
         errors++;
         $display("FAIL dbg_rdata: rvalid=%b rdata=%h, want 1 34", dbg_rvalid, dbg_rdata);
      end
      tick(); settle();
      checks++;
      if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h34) begin
         errors++;
         $display("FAIL dbg_hold: rvalid=%b rdata=%h, want 0 34", dbg_rvalid, dbg_rdata);
      end
   endtask

   task automatic test_starvation();
      logic exp_ready;
      tick(); idle_inputs(); cpu_req = 1; cpu_addr = 12'h010; dbg_valid = 1; dbg_addr = 12'h055;
      for (int c = 0; c <= 8; c++) begin
         settle();
         exp_ready = (c == 8);
         checks++;
         if (dbg_ready !== exp_ready || cpu_rdy !== !exp_ready) begin
            errors++;
            $display("FAIL starve_c%0d: ready=%b rdy=%b, want %b %b", c, dbg_ready, cpu_rdy, exp_ready, !exp_ready);
         end
         if (c == 8) begin
            checks++;
            if (rom_addr !== 12'h055 || cpu_data !== 8'h00) begin
               errors++;
               $display("FAIL starve_rom: addr=%h cpu_data=%h, want 055 00", rom_addr, cpu_data);
            end
         end
         tick();
      end
      dbg_valid = 0; settle();
      checks++;
      if (cpu_rdy !== 1'b1 || cpu_data !== 8'h9A || dbg_rvalid !== 1'b1 || dbg_rdata !== 8'hDF) begin
         errors++;
         $display("FAIL starve_after: rdy=%b data=%h rvalid=%b rdata=%h, want 1 9a 1 df",
                  cpu_rdy, cpu_data, dbg_rvalid, dbg_rdata);
      end
      tick(); idle_inputs(); settle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [4] = '{8'h8A, 8'h8B, 8'h88, 8'h89};
      tick(); idle_inputs();
      for (int c = 0; c < 5; c++) begin
         dbg_valid = (c < 4);
         dbg_addr  = (c < 4) ? ADDR_W'(c) : '0;
         settle();
         checks++;
         if (dbg_ready !== (c < 4) || dbg_rvalid !== (c > 0) ||
             (c > 0 && dbg_rdata !== exp_d[(c > 0) ? c - 1 : 0]) || dut.wait_q !== '0) begin
            errors++;
            $display("FAIL b2b_c%0d: ready=%b rvalid=%b rdata=%h wait=%0d, want %b %b %h 0",
                     c, dbg_ready, dbg_rvalid, dbg_rdata, dut.wait_q, (c < 4), (c > 0),
                     exp_d[(c > 0) ? c - 1 : 0]);
         end
         tick();
      end
      idle_inputs(); settle();
   endtask

   task automatic test_reset_mid_wait();
      logic exp_ready;
      tick(); idle_inputs(); cpu_req = 1; cpu_addr = 12'h020; dbg_valid = 1; dbg_addr = 12'h066;
      for (int c = 0; c < 5; c++) tick();
      rst = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (dbg_ready !== 1'b0 || cpu_rdy !== 1'b1 || dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_c%0d: ready=%b rdy=%b rvalid=%b, want 0 1 0", c, dbg_ready, cpu_rdy, dbg_rvalid);
         end
         tick();
      end
      rst = 0;
      for (int c = 0; c <= 8; c++) begin
         settle();
         exp_ready = (c == 8);
         checks++;
         if (dbg_ready !== exp_ready || cpu_rdy !== !exp_ready || dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after_c%0d: ready=%b rdy=%b rvalid=%b, want %b %b 0",
                     c, dbg_ready, cpu_rdy, dbg_rvalid, exp_ready, !exp_ready);
         end
         tick();
      end
      idle_inputs(); settle();
   endtask

   task automatic test_reset_after_grant();
      tick(); idle_inputs(); dbg_valid = 1; dbg_addr = 12'h077; settle();
      checks++;
      if (dbg_ready !== 1'b1) begin
         errors++;
         $display("FAIL rag_grant: ready=%b, want 1", dbg_ready);
      end
      tick(); idle_inputs(); rst = 1; settle();
      checks++;
      if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h00) begin
         errors++;
         $display("FAIL rag_rst: rvalid=%b rdata=%h, want 0 00", dbg_rvalid, dbg_rdata);
      end
      tick(); rst = 0; settle();
      checks++;
      if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h00) begin
         errors++;
         $display("FAIL rag_after: rvalid=%b rdata=%h, want 0 00", dbg_rvalid, dbg_rdata);
      end
   endtask

   task automatic test_random_invariants();
      logic prev_stall = 1'b0;
      tick(); idle_inputs();
      for (int c = 0; c < 300; c++) begin
         cpu_req  = ($urandom_range(0, 9) < 8);
         cpu_vec  = $urandom_range(0, 1);
         cpu_addr = ADDR_W'($urandom);
         if (!dbg_valid) begin
            dbg_valid = $urandom_range(0, 1);
            dbg_vec   = $urandom_range(0, 1);
            dbg_addr  = ADDR_W'($urandom);
         end
         settle();
         checks++;
         if ((sel_fw && sel_vec) || (prev_stall && !cpu_rdy)) begin
            errors++;
            $display("FAIL rand_c%0d: fw=%b vec=%b rdy=%b prev_stall=%b", c, sel_fw, sel_vec, cpu_rdy, prev_stall);
         end
         prev_stall = !cpu_rdy;
         if (dbg_ready) dbg_valid = 0;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_cpu_only();
      test_dbg_vector();
      test_starvation();
      test_back_to_back();
      test_reset_mid_wait();
      test_reset_after_grant();
      test_random_invariants();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
